sik_stack_unit: RTL and testbench

Parametrised multi-context operand stack for the SIK stack processor. It replaces the fixed pair of 8-bit stack pointers and the shared register file with N independent hardware thread stacks. Each stack has configurable width and depth, occupancy tracking, and sticky overflow/underflow faults. It executes one stack/ALU micro-op per cycle from the decode stage and returns the new top-of-stack one cycle later.

---
 rtl/sik_stack_unit.sv | 204 ++++++++++++++++++++
 tb/tb_sik_stack_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sik_stack_unit.sv
// sik_stack_unit: multi-context operand stack for the SIK stack processor.
// One stack/ALU micro-op per cycle, registered result one cycle later.
// Each thread has its own sp/cnt and a sticky fault flag that locks the
// thread out until reset.
module sik_stack_unit #(
    parameter int WIDTH        = 16,
    parameter int DEPTH_LOG2   = 8,
    parameter int THREADS_LOG2 = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    input  logic [THREADS_LOG2-1:0]   op_thread,
    input  logic [3:0]                op_code,
    input  logic [DEPTH_LOG2-1:0]     op_imm,
    input  logic [WIDTH-1:0]          op_data,
    output logic                      res_valid,
    output logic [THREADS_LOG2-1:0]   res_thread,
    output logic [WIDTH-1:0]          res_data,
    output logic                      res_fault,
    output logic [(1<<THREADS_LOG2)-1:0] fault
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int THREADS = 1 << THREADS_LOG2;
    localparam int AW      = THREADS_LOG2 + DEPTH_LOG2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LT   = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_DUP  = 4'h7;
    localparam logic [3:0] OP_PUSH = 4'h8;
    localparam logic [3:0] OP_POP  = 4'h9;
    localparam logic [3:0] OP_GET  = 4'hA;
    localparam logic [3:0] OP_PUT  = 4'hB;

    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_TWO  = (DEPTH_LOG2+1)'(2);

    logic [WIDTH-1:0]      mem_q [THREADS*DEPTH];
    logic [DEPTH_LOG2-1:0] sp_q  [THREADS];
    logic [DEPTH_LOG2:0]   cnt_q [THREADS];
    logic [THREADS-1:0]    fault_q;

    logic                    res_valid_q;
    logic [THREADS_LOG2-1:0] res_thread_q;
    logic [WIDTH-1:0]        res_data_q;
    logic                    res_fault_q;

    logic [DEPTH_LOG2-1:0] sp, sp_m1, sp_p1, sp_mk;
    logic [DEPTH_LOG2:0]   cnt;
    logic [WIDTH-1:0]      a, b, g, alu;
    logic                  full, empty, k_ge, ignored;

    logic                  op_bad;
    logic                  we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [WIDTH-1:0]      wdata;
    logic [DEPTH_LOG2-1:0] sp_d;
    logic [DEPTH_LOG2:0]   cnt_d;
    logic                  commit;
    logic                  res_fault_d;
    logic [WIDTH-1:0]      res_data_d;

    assign sp      = sp_q[op_thread];
    assign cnt     = cnt_q[op_thread];
    assign sp_m1   = sp - 1'b1;
    assign sp_p1   = sp + 1'b1;
    assign sp_mk   = sp - op_imm;
    assign b       = mem_q[{op_thread, sp}];
    assign a       = mem_q[{op_thread, sp_m1}];
    assign g       = mem_q[{op_thread, sp_mk}];
    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign k_ge    = ({1'b0, op_imm} >= cnt);
    assign ignored = fault_q[op_thread];

    // ALU result for binary ops: a is second-from-top, b is top
    always_comb begin
        alu = '0;
        case (op_code)
            OP_ADD:  alu = a + b;
            OP_LT:   alu = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            default: alu = '0;
        endcase
    end

    // Decode: fault check, single memory write, new sp/cnt, result word
    always_comb begin
        op_bad = 1'b0;
        we     = 1'b0;
        waddr  = sp;
        wdata  = b;
        sp_d   = sp;
        cnt_d  = cnt;
        case (op_code)
            OP_NOP: ;
            OP_ADD, OP_LT, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                if (cnt < CNT_TWO) begin
                    op_bad = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = sp_m1;
                    wdata = alu;
                    sp_d  = sp_m1;
                    cnt_d = cnt - 1'b1;
                end
            end
            OP_DUP, OP_PUSH, OP_GET: begin
                if (full || (op_code == OP_DUP && empty) || (op_code == OP_GET && k_ge)) begin
                    op_bad = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = sp_p1;
                    wdata = (op_code == OP_PUSH) ? op_data :
                            (op_code == OP_GET)  ? g : b;
                    sp_d  = sp_p1;
                    cnt_d = cnt + 1'b1;
                end
            end
            OP_POP: begin
                if (empty) begin
                    op_bad = 1'b1;
                end else begin
                    sp_d  = sp_m1;
                    cnt_d = cnt - 1'b1;
                end
            end
            OP_PUT: begin
                if (empty || k_ge) begin
                    op_bad = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = sp_mk;
                    wdata = b;
                    sp_d  = sp_m1;
                    cnt_d = cnt - 1'b1;
                end
            end
            default: op_bad = 1'b1;
        endcase

        res_fault_d = ignored | op_bad;
        commit      = op_valid & ~res_fault_d;

        // New top may be the word written this cycle, so forward it
        if (res_fault_d || cnt_d == '0)
            res_data_d = '0;
        else if (we && waddr == sp_d)
            res_data_d = wdata;
        else
            res_data_d = mem_q[{op_thread, sp_d}];
    end

    // Control state and registered result; async reset empties every stack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < THREADS; i++) begin
                sp_q[i]  <= '1;
                cnt_q[i] <= '0;
            end
            fault_q      <= '0;
            res_valid_q  <= 1'b0;
            res_thread_q <= '0;
            res_data_q   <= '0;
            res_fault_q  <= 1'b0;
        end else begin
            res_valid_q <= op_valid;
            if (op_valid) begin
                res_thread_q <= op_thread;
                res_data_q   <= res_data_d;
                res_fault_q  <= res_fault_d;
                if (res_fault_d)
                    fault_q[op_thread] <= 1'b1;
            end
            if (commit) begin
                sp_q[op_thread]  <= sp_d;
                cnt_q[op_thread] <= cnt_d;
            end
        end
    end

    // Stack storage, never cleared; a write landing during reset is harmless
    // because reset leaves every stack empty, so that word is never read back
    always_ff @(posedge clk) begin
        if (commit && we)
            mem_q[AW'({op_thread, waddr})] <= wdata;
    end

    assign res_valid  = res_valid_q;
    assign res_thread = res_thread_q;
    assign res_data   = res_data_q;
    assign res_fault  = res_fault_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_sik_stack_unit.sv
// Scoreboard bench for sik_stack_unit: a queue-based stack model predicts each
// result; a negedge monitor pops and compares whenever res_valid is seen.
module tb_sik_stack_unit;

    localparam int W       = 16;
    localparam int DL      = 2;
    localparam int TL      = 1;
    localparam int DEPTH   = 1 << DL;
    localparam int THREADS = 1 << TL;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic [TL-1:0] op_thread;
    logic [3:0]    op_code;
    logic [DL-1:0] op_imm;
    logic [W-1:0]  op_data;
    logic          res_valid;
    logic [TL-1:0] res_thread;
    logic [W-1:0]  res_data;
    logic          res_fault;
    logic [THREADS-1:0] fault;

    sik_stack_unit #(.WIDTH(W), .DEPTH_LOG2(DL), .THREADS_LOG2(TL)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_thread(op_thread),
        .op_code(op_code), .op_imm(op_imm), .op_data(op_data),
        .res_valid(res_valid), .res_thread(res_thread), .res_data(res_data),
        .res_fault(res_fault), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TL-1:0]      thr;
        logic [W-1:0]       data;
        logic               flt;
        logic [THREADS-1:0] fv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [W-1:0]       stk [THREADS][$];
    logic [THREADS-1:0] m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int t = 0; t < THREADS; t++) stk[t].delete();
        m_fault = '0;
    endfunction

    // Behavioural stack: the back of the queue is top-of-stack
    function automatic void model_op(input int t, input logic [3:0] c, input int k,
                                     input logic [W-1:0] d,
                                     output logic [W-1:0] rd, output logic rf);
        int n;
        logic bad;
        logic [W-1:0] a, b, r;
        n   = stk[t].size();
        bad = 1'b0;
        if (m_fault[t]) begin
            rd = '0;
            rf = 1'b1;
            return;
        end
        if (c >= 4'h1 && c <= 4'h6) begin
            if (n < 2) bad = 1'b1;
            else begin
                b = stk[t].pop_back();
                a = stk[t].pop_back();
                case (c)
                    4'h1: r = a + b;
                    4'h2: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
                    4'h3: r = a - b;
                    4'h4: r = a & b;
                    4'h5: r = a | b;
                    default: r = a ^ b;
                endcase
                stk[t].push_back(r);
            end
        end else if (c == 4'h7) begin
            if (n == DEPTH || n == 0) bad = 1'b1;
            else stk[t].push_back(stk[t][n-1]);
        end else if (c == 4'h8) begin
            if (n == DEPTH) bad = 1'b1;
            else stk[t].push_back(d);
        end else if (c == 4'h9) begin
            if (n == 0) bad = 1'b1;
            else void'(stk[t].pop_back());
        end else if (c == 4'hA) begin
            if (n == DEPTH || k >= n) bad = 1'b1;
            else stk[t].push_back(stk[t][n-1-k]);
        end else if (c == 4'hB) begin
            if (n == 0 || k >= n) bad = 1'b1;
            else begin
                stk[t][n-1-k] = stk[t][n-1];
                void'(stk[t].pop_back());
            end
        end else if (c != 4'h0) begin
            bad = 1'b1;
        end
        if (bad) m_fault[t] = 1'b1;
        rf = bad;
        rd = (bad || stk[t].size() == 0) ? '0 : stk[t][stk[t].size()-1];
    endfunction

    task automatic issue(input int t, input logic [3:0] c, input int k, input logic [W-1:0] d);
        exp_t e;
        logic [W-1:0] rd;
        logic rf;
        @(posedge clk);
        #1;
        op_valid  = 1'b1;
        op_thread = TL'(t);
        op_code   = c;
        op_imm    = DL'(k);
        op_data   = d;
        model_op(t, c, k, d, rd, rf);
        e.thr  = TL'(t);
        e.data = rd;
        e.flt  = rf;
        e.fv   = m_fault;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Called shortly after an edge: reset lands between edges, outputs clear at once
    task automatic do_reset();
        #1;
        op_valid = 1'b0;
        reset    = 1'b1;
        sb.delete();
        model_clear();
        #1;
        check("rst_res_valid",  32'(res_valid),  32'd0);
        check("rst_res_data",   32'(res_data),   32'd0);
        check("rst_res_fault",  32'(res_fault),  32'd0);
        check("rst_res_thread", 32'(res_thread), 32'd0);
        check("rst_fault",      32'(fault),      32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: every presented result must match the oldest prediction
    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got res_valid=1 expected no result at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("res_thread", 32'(res_thread), 32'(mon_e.thr));
                check("res_data",   32'(res_data),   32'(mon_e.data));
                check("res_fault",  32'(res_fault),  32'(mon_e.flt));
                check("fault_vec",  32'(fault),      32'(mon_e.fv));
            end
        end
    end

    initial begin
        logic [3:0] c;
        logic [W-1:0] d;
        int waited;
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_thread = '0;
        op_code   = '0;
        op_imm    = '0;
        op_data   = '0;
        model_clear();
        #3;
        check("init_res_valid", 32'(res_valid), 32'd0);
        check("init_res_data",  32'(res_data),  32'd0);
        check("init_fault",     32'(fault),     32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // add, then pop shows one entry was left
        issue(0, 4'h8, 0, 16'd5);
        issue(0, 4'h8, 0, 16'd3);
        issue(0, 4'h1, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        // lt unsigned-looking and signed cases, sub wrap
        issue(0, 4'h8, 0, 16'd3);
        issue(0, 4'h8, 0, 16'd5);
        issue(0, 4'h2, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        issue(0, 4'h8, 0, 16'hFFFF);
        issue(0, 4'h8, 0, 16'd1);
        issue(0, 4'h2, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        issue(0, 4'h8, 0, 16'd1);
        issue(0, 4'h8, 0, 16'hFFFF);
        issue(0, 4'h3, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        // interleaved threads
        issue(0, 4'h8, 0, 16'hA);
        issue(1, 4'h8, 0, 16'hB);
        issue(0, 4'h7, 0, 16'd0);
        issue(1, 4'h9, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        // get/put, including put k=0 and a NOP
        issue(0, 4'h8, 0, 16'd1);
        issue(0, 4'h8, 0, 16'd2);
        issue(0, 4'h8, 0, 16'd3);
        issue(0, 4'hA, 2, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        issue(0, 4'hB, 1, 16'd0);
        issue(0, 4'h0, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        issue(0, 4'h8, 0, 16'd9);
        issue(0, 4'h8, 0, 16'd4);
        issue(0, 4'hB, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        // overflow on thread 1 locks it; thread 0 keeps working
        for (int i = 0; i < 5; i++) issue(1, 4'h8, 0, W'(i + 1));
        issue(1, 4'h1, 0, 16'd0);
        issue(0, 4'h8, 0, 16'd7);
        issue(0, 4'h9, 0, 16'd0);
        issue(0, 4'h9, 0, 16'd0);
        idle();
        do_reset();
        // reserved opcode
        issue(0, 4'hD, 0, 16'd0);
        issue(1, 4'h8, 0, 16'h55);
        idle();
        do_reset();
        // reset mid-stream, then pop must see an empty stack
        for (int i = 0; i < 4; i++) issue(0, 4'h8, 0, W'(16'h100 + i));
        do_reset();
        issue(0, 4'h9, 0, 16'd0);
        idle();
        do_reset();

        // randomized rounds, each started from reset
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    idle();
                end else begin
                    if ($urandom_range(0, 9) < 4) c = 4'h8;
                    else if ($urandom_range(0, 19) == 0) c = 4'($urandom_range(0, 15));
                    else c = 4'($urandom_range(0, 11));
                    case ($urandom_range(0, 3))
                        0: d = 16'h7FFF;
                        1: d = 16'h8000;
                        default: d = 16'($urandom);
                    endcase
                    issue($urandom_range(0, THREADS-1), c, $urandom_range(0, DEPTH-1), d);
                end
            end
            idle();
            if (r != 24) do_reset();
        end

        idle();
        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d results outstanding expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
